// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, claim and writeback bus between the issue/writeback logic and regfile_sb
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
);
    logic            ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rdat1;
    logic [XLEN-1:0] rdat2;
    logic            busy1;
    logic            busy2;
    logic            claim;
    logic [AW-1:0]   claim_addr;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdat;
    logic            waw_err;
    modport master (
        output rs1, rs2, claim, claim_addr, we, waddr, wdat,
        input  ready, rdat1, rdat2, busy1, busy2, waw_err
    );
    modport slave (
        input  rs1, rs2, claim, claim_addr, we, waddr, wdat,
        output ready, rdat1, rdat2, busy1, busy2, waw_err
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with RAW scoreboard, optional write-to-read bypass and zeroing init sequencer
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_sb;
    logic            r_ready;
    logic            r_waw;
    logic [NREG-1:0] w_sb_nxt;
    logic            w_run;
    logic            w_wr;
    logic            w_clm;
    logic            w_hit1;
    logic            w_hit2;

    // register 0 is hardwired, so writes and claims to it never take effect
    assign w_run  = r_state == ST_RUN;
    assign w_wr   = w_run && bus.we && bus.waddr != '0;
    assign w_clm  = w_run && bus.claim && bus.claim_addr != '0;
    assign w_hit1 = (BYPASS != 0) && w_wr && bus.waddr == bus.rs1;
    assign w_hit2 = (BYPASS != 0) && w_wr && bus.waddr == bus.rs2;

    assign bus.rdat1   = (!w_run || bus.rs1 == '0) ? '0 : w_hit1 ? bus.wdat : r_mem[bus.rs1];
    assign bus.rdat2   = (!w_run || bus.rs2 == '0) ? '0 : w_hit2 ? bus.wdat : r_mem[bus.rs2];
    assign bus.busy1   = w_run && r_sb[bus.rs1] && !w_hit1;
    assign bus.busy2   = w_run && r_sb[bus.rs2] && !w_hit2;
    assign bus.ready   = r_ready;
    assign bus.waw_err = r_waw;

    // next scoreboard: writeback retires the producer, a claim applied last so a new producer wins
    always_comb begin
        w_sb_nxt = r_sb;
        if (w_wr) w_sb_nxt[bus.waddr] = 1'b0;
        if (w_clm) w_sb_nxt[bus.claim_addr] = 1'b1;
    end

    // array: zero one entry per cycle during init, then accept writebacks
    always_ff @(posedge clk) begin
        if (!rst && !w_run) r_mem[r_cnt] <= '0;
        else if (!rst && w_wr) r_mem[bus.waddr] <= bus.wdat;
    end

    // sequencer, ready flag, scoreboard and WAW detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_sb    <= '0;
            r_ready <= 1'b0;
            r_waw   <= 1'b0;
        end else if (!w_run) begin
            r_cnt <= r_cnt + AW'(1);
            r_waw <= 1'b0;
            if (r_cnt == AW'(NREG - 1)) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end else begin
            r_sb  <= w_sb_nxt;
            r_waw <= w_clm && r_sb[bus.claim_addr] && !(w_wr && bus.waddr == bus.claim_addr);
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: bypass and non-bypass register files driven in lockstep against a behavioural model
module tb_regfile_sb;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rs1 = '0, rs2 = '0, ca = '0, wa = '0;
    logic          claim = 1'b0, we = 1'b0;
    logic [31:0]   wd = '0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            m_left;
    logic [31:0]   m_mem [NREG];
    logic          m_sb [NREG];
    logic          m_waw;

    regfile_sb_if #(.XLEN(32), .NREG(NREG)) b1 ();
    regfile_sb_if #(.XLEN(32), .NREG(NREG)) b0 ();

    assign b1.rs1 = rs1;  assign b1.rs2 = rs2;  assign b1.claim = claim;  assign b1.claim_addr = ca;
    assign b1.we = we;    assign b1.waddr = wa; assign b1.wdat = wd;
    assign b0.rs1 = rs1;  assign b0.rs2 = rs2;  assign b0.claim = claim;  assign b0.claim_addr = ca;
    assign b0.we = we;    assign b0.waddr = wa; assign b0.wdat = wd;

    regfile_sb #(.XLEN(32), .NREG(NREG), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    regfile_sb #(.XLEN(32), .NREG(NREG), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] rs, input bit byp);
        if (m_left != 0 || rs == 0) return 32'h0;
        if (byp && we && wa == rs) return wd;
        return m_mem[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs, input bit byp);
        if (m_left != 0) return 1'b0;
        return m_sb[rs] && !(byp && we && wa == rs);
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_left = NREG;
            m_waw  = 1'b0;
            for (int i = 0; i < NREG; i++) begin
                m_mem[i] = '0;
                m_sb[i]  = 1'b0;
            end
        end else if (m_left > 0) begin
            m_left--;
            m_waw = 1'b0;
        end else begin
            m_waw = claim && ca != 0 && m_sb[ca] && !(we && wa == ca);
            if (we && wa != 0) begin
                m_mem[wa] = wd;
                m_sb[wa]  = 1'b0;
            end
            if (claim && ca != 0) m_sb[ca] = 1'b1;
        end
    endtask

    task automatic cyc();
        #1;
        chk("b1_rdat1", b1.rdat1, exp_rd(rs1, 1'b1));
        chk("b1_rdat2", b1.rdat2, exp_rd(rs2, 1'b1));
        chk("b1_busy1", 32'(b1.busy1), 32'(exp_busy(rs1, 1'b1)));
        chk("b1_busy2", 32'(b1.busy2), 32'(exp_busy(rs2, 1'b1)));
        chk("b0_rdat1", b0.rdat1, exp_rd(rs1, 1'b0));
        chk("b0_rdat2", b0.rdat2, exp_rd(rs2, 1'b0));
        chk("b0_busy1", 32'(b0.busy1), 32'(exp_busy(rs1, 1'b0)));
        chk("b0_busy2", 32'(b0.busy2), 32'(exp_busy(rs2, 1'b0)));
        @(posedge clk);
        model_edge();
        #1;
        chk("b1_ready", 32'(b1.ready), 32'(m_left == 0));
        chk("b0_ready", 32'(b0.ready), 32'(m_left == 0));
        chk("b1_waw", 32'(b1.waw_err), 32'(m_waw));
        chk("b0_waw", 32'(b0.waw_err), 32'(m_waw));
    endtask

    task automatic wait_ready(input string tag, input int exp_edges);
        int n = 0;
        while (!b1.ready && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_edges));
    endtask

    task automatic idle();
        we = 1'b0;
        claim = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        chk("rst_ready", 32'(b1.ready), 32'h0);
        chk("rst_waw", 32'(b1.waw_err), 32'h0);
        rst = 1'b0;
        wait_ready("init_edges", NREG);
        for (int i = 0; i < NREG; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(NREG - 1 - i);
            cyc();
        end
        we = 1'b1; wa = 5; wd = 32'hDEADBEEF; rs1 = 5;
        cyc();
        idle();
        cyc();
        claim = 1'b1; ca = 7; rs2 = 7;
        cyc();
        idle();
        cyc();
        we = 1'b1; wa = 7; wd = 32'h1234;
        cyc();
        idle();
        cyc();
        claim = 1'b1; ca = 0; rs1 = 0;
        cyc();
        idle(); we = 1'b1; wa = 0; wd = 32'hFFFFFFFF;
        cyc();
        idle(); claim = 1'b1; ca = 3; rs1 = 3;
        cyc();
        cyc();
        idle();
        cyc();
        claim = 1'b1; ca = 3; we = 1'b1; wa = 3; wd = 32'hA5A5A5A5;
        cyc();
        idle();
        cyc();
        claim = 1'b1; ca = 4;
        cyc();
        idle(); we = 1'b1; wa = 9; wd = 32'h55; rs1 = 4; rs2 = 9;
        cyc();
        idle(); rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; wa = 9; wd = $urandom; claim = 1'b1; ca = AW'(i + 1);
            cyc();
        end
        idle();
        wait_ready("reinit_edges", NREG - 6);
        rs1 = 4; rs2 = 9;
        cyc();
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom % 300) == 0;
            we    = 1'($urandom);
            claim = ($urandom % 3) == 0;
            ca    = AW'($urandom % 8);
            wa    = AW'($urandom % 8);
            rs1   = AW'($urandom % 8);
            rs2   = AW'($urandom % NREG);
            wd    = $urandom;
            cyc();
        end
        rst = 1'b0;
        idle();
        wait_ready("rand_ready", 32'(m_left));
        for (int i = 1; i < NREG; i++) begin
            we = 1'b1; wa = AW'(i); wd = $urandom | 32'h1;
            cyc();
        end
        idle(); rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_ready("final_init", NREG);
        for (int i = 0; i < NREG; i++) begin
            rs1 = AW'(i);
            rs2 = AW'(NREG - 1 - i);
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in scoreboard, write-to-read bypass and a self-clearing init sequencer. It replaces the fixed 32x32 register file in the core's decode/writeback path. The scoreboard lets the issue stage detect RAW hazards against in-flight producers, such as multi-cycle loads. After reset, the init sequencer zeroes the array one entry per cycle before the core may issue.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, at least 2
- AW, $clog2(NREG), register address width (derived)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high once init has finished; issue is allowed only while high
- rs1  in  AW  read port 1 address
- rs2  in  AW  read port 2 address
- rdat1  out  XLEN  read port 1 data (combinational)
- rdat2  out  XLEN  read port 2 data (combinational)
- busy1  out  1  register rs1 has a pending producer (combinational)
- busy2  out  1  register rs2 has a pending producer (combinational)
- claim  in  1  mark claim_addr busy (instruction issued with this destination)
- claim_addr  in  AW  destination being claimed
- we  in  1  writeback enable
- waddr  in  AW  writeback address
- wdat  in  XLEN  writeback data
- waw_err  out  1  one-cycle registered pulse: a claim hit an already-busy register

## Operation
- States: INIT, RUN. Reset forces INIT, cnt=0, all scoreboard bits=0, waw_err=0, ready=0.
- INIT:
  - Each edge writes 0 to reg[cnt] and increments cnt.
  - When cnt==NREG-1, the state moves to RUN on that edge.
  - In INIT: rdat1/rdat2=0, busy1/busy2=0; we and claim are ignored.
- RUN, register 0:
  - Reads always 0; never busy.
  - Writes to it are dropped; claims of it are dropped and raise no waw_err.
- RUN, write: if we and waddr!=0, reg[waddr]<=wdat and sb[waddr]<=0 at the edge.
- RUN, claim: if claim and claim_addr!=0, sb[claim_addr]<=1 at the edge.
- Same register claimed and written in the same cycle:
  - Data is written.
  - sb ends at 1, because the claim (a new producer) wins.
  - No waw_err is raised.
- waw_err: asserted on the next edge when claim, claim_addr!=0, sb[claim_addr]==1 and there is no same-cycle write to claim_addr. The claim still sets the bit.
- Read, BYPASS=1:
  - rdatN = wdat if we and waddr==rsN and rsN!=0; otherwise reg[rsN].
  - busyN = sb[rsN] and not (we and waddr==rsN).
- Read, BYPASS=0: rdatN = reg[rsN]; busyN = sb[rsN]; the new value and cleared busy are visible the cycle after the write.
- A write to a register that is not busy is legal; sb stays 0.
- rst asserted mid-RUN, including with pending claims: everything returns to the INIT state on that edge. Array contents are not trusted until ready=1 again.

## Timing
- ready is registered:
  - Assert at the edge where the state enters RUN.
  - This is NREG rising edges after the first edge with rst=0, following the reset edge.
  - Deasserts on the edge rst is sampled high.
- Read latency is 0 (combinational from rsN, reg, sb, and, with BYPASS=1, from we/waddr/wdat).
- Write latency is 1 edge; scoreboard set and clear are 1 edge.
- waw_err lasts exactly one cycle per offending claim. Back-to-back offending claims give consecutive pulses.
- Reset values:
  - ready=0, waw_err=0.
  - rdat1/rdat2=0 and busy1/busy2=0 throughout INIT.

## Test plan
- Init, NREG=32:
  - Stimulus: rst high 2 cycles, then low.
  - Required: ready=0 for exactly 32 edges, then 1.
  - Preload garbage via hierarchical write before reset; every register reads 0 after ready.
- Write and read, BYPASS=1:
  - Stimulus: we=1, waddr=5, wdat=0xDEADBEEF, rs1=5 in the same cycle.
  - Required: rdat1=0xDEADBEEF in that cycle; still 0xDEADBEEF the next cycle with we=0.
  - Repeat with BYPASS=0: old value (0) in the same cycle, 0xDEADBEEF next cycle.
- Scoreboard:
  - Stimulus: claim r7, then rs2=7.
  - Required: busy2=1 from the next cycle.
  - Stimulus: writeback r7=0x1234.
  - Required: busy2=0 in the writeback cycle (BYPASS=1), rdat2=0x1234.
- Register 0:
  - Stimulus: claim r0, then we=1 waddr=0 wdat=0xFFFFFFFF.
  - Required: rdat1=0 with rs1=0, busy1=0, waw_err never set.
- Hazards:
  - Stimulus: claim r3 twice without a write between.
  - Required: waw_err pulses for one cycle after the second claim.
  - Stimulus: claim r3 and write r3 in the same cycle.
  - Required: no waw_err; busy remains 1 afterward.
- Reset mid-operation:
  - Stimulus: with r4 busy and r9=0x55, assert rst for 1 cycle.
  - Required: ready drops at that edge, busy1=0 for rs1=4, and 32 edges later ready=1 with r9=0.
  - Also: we/claim driven during INIT have no effect.
